// File: rtl/toggle_hs_pkg.sv
// Shared definitions for the toggle-handshake link (sender and receiver).
//   state_t          : receiver FSM states
//   DEF_DATA_W       : default word width
//   DEF_SYNC_STAGES  : default synchroniser depth for the toggle lines
//   DEF_CNT_W        : default received-word counter width
package toggle_hs_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/bit_sync.sv
// Single-bit multi-flop synchroniser with asynchronous active-high reset to 0.
// Shared between the receiver (req_tgl) and the sender (ack_tgl).
//   clk    in  destination clock
//   reset  in  asynchronous, active-high reset
//   d      in  asynchronous input bit
//   q      out synchronised bit (last stage)
module bit_sync #(
  parameter int SYNC_STAGES = 2   // legal range 2..4
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  // sync_q[0] is the metastability-catching flop; the word shifts toward the MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_hs_receiver.sv
// Receive end of the toggle-handshake link.
// Synchronises req_tgl, detects each flip, captures req_data and presents it
// on a valid/ready port; flips ack_tgl once the word is consumed.
//   clk, reset  clock and asynchronous active-high reset
//   req_tgl     in  request toggle from sender (asynchronous)
//   req_data    in  word from sender, stable around each req_tgl flip
//   ack_tgl     out acknowledge toggle back to sender (registered)
//   out_valid   out captured word available
//   out_data    out captured word (registered)
//   out_ready   in  downstream accepts the word
//   rx_count    out words delivered, wraps modulo 2^CNT_W
//   err         out sticky: sender toggled again before being acknowledged
//
// state | meaning
// IDLE  | no word held, waiting for a req_tgl flip
// HOLD  | word held on out_data, waiting for out_ready
module toggle_hs_receiver
  import toggle_hs_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack_tgl,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  rx_count,
  output logic              err
);

  state_t              state_q, state_d;
  logic                req_sync;
  logic                req_prev_q;
  logic                detect;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                ack_q, ack_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  bit_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d     (req_tgl),
    .q     (req_sync)
  );

  // One-cycle pulse per flip of the synchronised toggle.
  assign detect = req_sync ^ req_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_prev_q <= 1'b0;
      data_q     <= '0;
      ack_q      <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_prev_q <= req_sync;
      data_q     <= data_d;
      ack_q      <= ack_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ack_d   = ack_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        // req_data has been stable for SYNC_STAGES cycles by the time the
        // flip reaches detect, so it is captured without synchronisation.
        if (detect) begin
          data_d  = req_data;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // A flip while a word is still held is a protocol violation; the new
        // word is dropped, even if the handshake completes on the same edge.
        if (detect) begin
          err_d = 1'b1;
        end
        if (out_ready) begin
          ack_d   = ~ack_q;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign ack_tgl   = ack_q;
  assign rx_count  = cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_toggle_hs_receiver.sv
module tb_toggle_hs_receiver;

  logic clk;
  logic reset;

  // default instance
  logic       req_tgl, out_ready, ack_tgl, out_valid, err;
  logic [7:0] req_data, out_data, rx_count;

  // CNT_W = 2 instance
  logic       w_req_tgl, w_out_ready, w_ack_tgl, w_out_valid, w_err;
  logic [7:0] w_req_data, w_out_data;
  logic [1:0] w_rx_count;

  // SYNC_STAGES = 3 instance
  logic       s_req_tgl, s_out_ready, s_ack_tgl, s_out_valid, s_err;
  logic [7:0] s_req_data, s_out_data, s_rx_count;

  int n_cmp = 0;
  int n_bad = 0;

  toggle_hs_receiver u_dut (
    .clk(clk), .reset(reset), .req_tgl(req_tgl), .req_data(req_data),
    .ack_tgl(ack_tgl), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .rx_count(rx_count), .err(err)
  );

  toggle_hs_receiver #(.CNT_W(2)) u_wrap (
    .clk(clk), .reset(reset), .req_tgl(w_req_tgl), .req_data(w_req_data),
    .ack_tgl(w_ack_tgl), .out_valid(w_out_valid), .out_data(w_out_data),
    .out_ready(w_out_ready), .rx_count(w_rx_count), .err(w_err)
  );

  toggle_hs_receiver #(.SYNC_STAGES(3)) u_s3 (
    .clk(clk), .reset(reset), .req_tgl(s_req_tgl), .req_data(s_req_data),
    .ack_tgl(s_ack_tgl), .out_valid(s_out_valid), .out_data(s_out_data),
    .out_ready(s_out_ready), .rx_count(s_rx_count), .err(s_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         hold;     // cycles out_ready stays low after out_valid rises
    logic [7:0] exp_cnt;
    logic       exp_ack;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] exp_cnt;
    logic       exp_ack;
  } wvec_t;

  vec_t  tbl[4];
  wvec_t wtbl[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    logic prev_ack;
    int   to;

    tbl[0] = '{data: 8'hA5, hold: 0,  exp_cnt: 8'd1, exp_ack: 1'b1};
    tbl[1] = '{data: 8'h3C, hold: 10, exp_cnt: 8'd2, exp_ack: 1'b0};
    tbl[2] = '{data: 8'h5A, hold: 3,  exp_cnt: 8'd3, exp_ack: 1'b1};
    tbl[3] = '{data: 8'hFF, hold: 0,  exp_cnt: 8'd4, exp_ack: 1'b0};

    wtbl[0] = '{data: 8'd1, exp_cnt: 2'd1, exp_ack: 1'b1};
    wtbl[1] = '{data: 8'd2, exp_cnt: 2'd2, exp_ack: 1'b0};
    wtbl[2] = '{data: 8'd3, exp_cnt: 2'd3, exp_ack: 1'b1};
    wtbl[3] = '{data: 8'd4, exp_cnt: 2'd0, exp_ack: 1'b0};
    wtbl[4] = '{data: 8'd5, exp_cnt: 2'd1, exp_ack: 1'b1};

    reset = 1'b1;
    req_tgl = 1'b0;   req_data = 8'h00;   out_ready = 1'b0;
    w_req_tgl = 1'b0; w_req_data = 8'h00; w_out_ready = 1'b0;
    s_req_tgl = 1'b0; s_req_data = 8'h00; s_out_ready = 1'b0;
    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ack",   32'(ack_tgl),   32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_count", 32'(rx_count),  32'd0);
    check("rst_err",   32'(err),       32'd0);
    step(); step();
    reset = 1'b0;
    step();
    check("post_rst_valid", 32'(out_valid), 32'd0);

    // ---- table: single words, latency, backpressure, idle ready ----
    for (int i = 0; i < 4; i++) begin
      prev_ack  = ack_tgl;
      out_ready = (tbl[i].hold == 0);
      req_data  = tbl[i].data;
      req_tgl   = ~req_tgl;
      step();
      check($sformatf("v%0d_lat0_valid", i), 32'(out_valid), 32'd0);
      step();
      check($sformatf("v%0d_lat1_valid", i), 32'(out_valid), 32'd0);
      step();
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d_data", i),  32'(out_data),  32'(tbl[i].data));
      for (int h = 0; h < tbl[i].hold; h++) begin
        step();
        check($sformatf("v%0d_bp_valid", i), 32'(out_valid), 32'd1);
        check($sformatf("v%0d_bp_data", i),  32'(out_data),  32'(tbl[i].data));
        check($sformatf("v%0d_bp_ack", i),   32'(ack_tgl),   32'(prev_ack));
      end
      out_ready = 1'b1;
      step();
      check($sformatf("v%0d_acc_valid", i), 32'(out_valid), 32'd0);
      check($sformatf("v%0d_acc_ack", i),   32'(ack_tgl),   32'(tbl[i].exp_ack));
      check($sformatf("v%0d_acc_cnt", i),   32'(rx_count),  32'(tbl[i].exp_cnt));
      step(); step();
      check($sformatf("v%0d_idle_valid", i), 32'(out_valid), 32'd0);
      check($sformatf("v%0d_idle_cnt", i),   32'(rx_count),  32'(tbl[i].exp_cnt));
      check($sformatf("v%0d_idle_ack", i),   32'(ack_tgl),   32'(tbl[i].exp_ack));
    end

    // ---- protocol violation: second flip while holding ----
    out_ready = 1'b0;
    req_data  = 8'h11;
    req_tgl   = ~req_tgl;
    step(); step(); step();
    check("viol_valid", 32'(out_valid), 32'd1);
    check("viol_data",  32'(out_data),  32'h11);
    check("viol_err_pre", 32'(err), 32'd0);
    req_data = 8'h22;
    req_tgl  = ~req_tgl;
    step(); step(); step();
    check("viol_err",       32'(err),       32'd1);
    check("viol_hold_data", 32'(out_data),  32'h11);
    check("viol_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    check("viol_acc_valid", 32'(out_valid), 32'd0);
    check("viol_acc_cnt",   32'(rx_count),  32'd5);
    check("viol_acc_ack",   32'(ack_tgl),   32'd1);
    for (int c = 0; c < 6; c++) begin
      step();
      check("viol_no_second", 32'(out_valid), 32'd0);
    end
    check("viol_err_sticky", 32'(err), 32'd1);
    check("viol_cnt_final",  32'(rx_count), 32'd5);

    // ---- counter wrap, CNT_W = 2, sender model waits for ack ----
    w_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w_req_data = wtbl[i].data;
      w_req_tgl  = ~w_req_tgl;
      to = 0;
      while (w_out_valid !== 1'b1 && to < 20) begin
        step();
        to++;
      end
      check($sformatf("wrap%0d_valid", i), 32'(w_out_valid), 32'd1);
      check($sformatf("wrap%0d_data", i),  32'(w_out_data),  32'(wtbl[i].data));
      to = 0;
      while (w_ack_tgl !== w_req_tgl && to < 20) begin
        step();
        to++;
      end
      check($sformatf("wrap%0d_ack", i), 32'(w_ack_tgl),  32'(wtbl[i].exp_ack));
      check($sformatf("wrap%0d_cnt", i), 32'(w_rx_count), 32'(wtbl[i].exp_cnt));
    end
    check("wrap_err", 32'(w_err), 32'd0);

    // ---- latency with SYNC_STAGES = 3 ----
    s_out_ready = 1'b1;
    s_req_data  = 8'hA5;
    s_req_tgl   = 1'b1;
    step();
    check("s3_lat0", 32'(s_out_valid), 32'd0);
    step();
    check("s3_lat1", 32'(s_out_valid), 32'd0);
    step();
    check("s3_lat2", 32'(s_out_valid), 32'd0);
    step();
    check("s3_valid", 32'(s_out_valid), 32'd1);
    check("s3_data",  32'(s_out_data),  32'hA5);
    check("s3_ack_pre", 32'(s_ack_tgl), 32'd0);
    step();
    check("s3_acc_valid", 32'(s_out_valid), 32'd0);
    check("s3_acc_ack",   32'(s_ack_tgl),   32'd1);
    check("s3_acc_cnt",   32'(s_rx_count),  32'd1);

    // ---- asynchronous reset while holding a word ----
    out_ready = 1'b0;
    req_data  = 8'h77;
    req_tgl   = ~req_tgl;
    step(); step(); step();
    check("rh_valid", 32'(out_valid), 32'd1);
    check("rh_ack",   32'(ack_tgl),   32'd1);
    check("rh_data",  32'(out_data),  32'h77);
    #2;
    reset   = 1'b1;
    req_tgl = 1'b0;
    #1;
    check("rh_rst_valid", 32'(out_valid), 32'd0);
    check("rh_rst_ack",   32'(ack_tgl),   32'd0);
    check("rh_rst_cnt",   32'(rx_count),  32'd0);
    check("rh_rst_err",   32'(err),       32'd0);
    check("rh_rst_data",  32'(out_data),  32'd0);
    step(); step();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      check("rh_no_spurious", 32'(out_valid), 32'd0);
    end
    check("rh_cnt_after", 32'(rx_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/toggle_hs_receiver.md
Name: toggle_hs_receiver

Overview:
- Receive end of the team's toggle-handshake link; the sender is a T-flip-flop style toggle generator.
- The sender flips req_tgl once per word and holds req_data stable until it sees ack_tgl flip.
- This block synchronises req_tgl into clk, detects each flip, captures the word and presents it on a valid/ready port.
- Once the word is consumed, it flips ack_tgl back to the sender.

Parameters:
- DATA_W, 8, width of req_data/out_data
- SYNC_STAGES, 2, flip-flops in the req_tgl synchroniser (legal range 2..4)
- CNT_W, 8, width of the received-word counter

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_tgl  in  1  request toggle from sender; asynchronous to clk
- req_data  in  DATA_W  word from sender; stable from before a req_tgl flip until ack_tgl flips
- ack_tgl  out  1  acknowledge toggle back to sender; registered
- out_valid  out  1  captured word available
- out_data  out  DATA_W  captured word; registered
- out_ready  in  1  downstream accepts the word
- rx_count  out  CNT_W  words delivered, modulo 2^CNT_W
- err  out  1  sticky protocol-violation flag

Behaviour:
- Reset values: ack_tgl=0, out_valid=0, out_data=0, rx_count=0, err=0. All synchroniser stages=0, req_prev=0, state=IDLE.
- Link reset: the sender's req_tgl must also reset to 0, so both ends agree on parity.
- Synchroniser: chain s[0..SYNC_STAGES-1]. s[0] samples req_tgl; each later stage samples the previous stage every clk.
- Edge tracking: req_prev <= s[last] every cycle.
- Detect: detect = s[last] XOR req_prev. This is a one-cycle pulse per req_tgl flip.
- Latency: a req_tgl flip sampled at edge k gives s[last] at edge k+SYNC_STAGES-1 and out_valid=1 after edge k+SYNC_STAGES. With the default, out_valid rises 2 edges after the first sampling edge.
- FSM has two states:
  - IDLE: out_valid=0.
    - On detect: out_data <= req_data, out_valid <= 1, go to HOLD.
  - HOLD: out_valid=1 and out_data is held constant.
    - On out_valid & out_ready at an edge: out_valid <= 0, ack_tgl <= ~ack_tgl, rx_count <= rx_count+1 (wraps from all-ones to 0), go to IDLE.
    - On detect while in HOLD (sender toggled again without ack): err <= 1. The new word is not captured and the held word is undisturbed.
    - If detect and handshake occur at the same edge, err still sets, the handshake completes normally, and the new flip is lost.
- Capture safety: req_data is sampled only in the detect cycle. By protocol it has been stable for at least SYNC_STAGES cycles by then, so it is not synchronised.
- Backpressure: HOLD lasts indefinitely while out_ready=0. No ack is sent, so the sender cannot advance.
- Ready with no valid: out_ready while in IDLE has no effect.
- Minimum cycle time: one word takes at least SYNC_STAGES+1 clk cycles from req flip to ack flip. Throughput is further bounded by the sender's own synchronisation of ack_tgl.
- err is cleared only by reset.
- Reset mid-operation: all state returns immediately (asynchronously) to reset values. Any held word is dropped and ack_tgl returns to 0.
- No combinational path from any input to any output.

Decomposition:
- Shared package toggle_hs_pkg:
  - state typedef {IDLE, HOLD}
  - default constants for DATA_W and SYNC_STAGES, shared with the matching sender block
- Sub-module bit_sync: parameterised SYNC_STAGES single-bit synchroniser with asynchronous active-high reset to 0. It is reused for ack_tgl on the sender side.
- The remaining logic (edge detect, FSM, counter, err) stays in toggle_hs_receiver.

Test Plan:
- Single word, defaults:
  - Stimulus: reset, release; req_data=8'hA5; flip req_tgl 0->1 between edges; out_ready=1.
  - Required: out_valid=1 with out_data=A5 exactly 2 edges after the sampling edge. It is high for 1 cycle; ack_tgl goes 0->1 on the same edge out_valid drops; rx_count=1.
- Backpressure:
  - Stimulus: word 8'h3C with out_ready=0 for 10 cycles, then 1.
  - Required: out_valid and out_data=3C stable for all 10 cycles with ack_tgl unchanged. ack_tgl flips on the accept edge; rx_count increments once.
- Protocol violation:
  - Stimulus: in HOLD with word 8'h11, flip req_tgl again with req_data=8'h22.
  - Required: err=1 within SYNC_STAGES+1 cycles; out_data stays 11; after accept, out_valid=0 and no second word appears.
- Counter wrap with CNT_W=2:
  - Stimulus: 5 back-to-back words 1..5 with a model sender that waits for ack_tgl.
  - Required: outputs 1,2,3,4,5 in order; rx_count sequence 1,2,3,0,1; ack_tgl alternates 1,0,1,0,1.
- Reset in HOLD:
  - Stimulus: assert reset mid-cycle while out_valid=1, ack_tgl=1.
  - Required: out_valid, ack_tgl, rx_count, err and out_data go to 0 before the next clk edge. After release with req_tgl=0, no spurious out_valid.
- Latency with SYNC_STAGES=3:
  - Stimulus: same as the single-word scenario.
  - Required: out_valid rises 3 edges after the sampling edge.
